hm_tx_sched: RTL and testbench

- Sequencing controller for the Hamming(7,4) encoder `hm_enc`.
- Captures 4-bit info words from the pins into a small FIFO, one word per strobe pulse.
- Pops one word at a time, encodes it through one `hm_enc` instance, and shifts the 7-bit codeword out serially, LSB first, with framing and status flags.
- Sits in the same 8-in/8-out pin-limited user-module slot as the combinational encoder.

---
 rtl/hm_tx_sched.sv | 163 ++++++++++++++++
 tb/tb_hm_tx_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hm_tx_sched.sv
// Hamming(7,4) transmit sequencer: strobed 4-bit words go into a small FIFO and
// are sent one at a time as serial 7-bit codewords, LSB first, with a fixed idle gap.

module hm_enc (
  input  logic [3:0] d,
  output logic [6:0] c
);
  assign c[0] = d[0] ^ d[1] ^ d[3];
  assign c[1] = d[0] ^ d[2] ^ d[3];
  assign c[2] = d[0];
  assign c[3] = d[1] ^ d[2] ^ d[3];
  assign c[4] = d[1];
  assign c[5] = d[2];
  assign c[6] = d[3];
endmodule

module hm_tx_sched #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  logic       clk;
  logic       srst;
  logic [3:0] word;
  logic       strobe;
  logic       enable;

  assign clk    = io_in[0];
  assign srst   = io_in[1];
  assign word   = io_in[5:2];
  assign strobe = io_in[6];
  assign enable = io_in[7];

  state_t          state_reg, state_next;
  logic [6:0]      shift_reg, shift_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
  logic            strobe_q_reg;
  logic [3:0]      mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;
  logic            overflow_reg;

  logic       fifo_full, fifo_empty;
  logic       push, push_ok, pop;
  logic [3:0] head;
  logic [6:0] codeword;

  assign fifo_full  = (count_reg == CW'(DEPTH));
  assign fifo_empty = (count_reg == '0);

  // A push into a full FIFO still lands if the same edge frees a slot.
  assign push    = strobe & ~strobe_q_reg;
  assign push_ok = push & (~fifo_full | pop);

  assign head = mem_reg[rd_ptr_reg];

  hm_enc u_enc (
    .d (head),
    .c (codeword)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable && !fifo_empty) begin
          pop          = 1'b1;
          shift_next   = codeword;
          bit_cnt_next = 3'd0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        shift_next   = {1'b0, shift_reg[6:1]};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd6) begin
          gap_cnt_next = GW'(GAP_CYCLES - 1);
          state_next   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - GW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push_ok && pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      strobe_q_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      strobe_q_reg <= strobe;
      count_reg    <= count_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!srst && push_ok) begin
      mem_reg[wr_ptr_reg] <= word;
    end
  end

  assign io_out[0]   = (state_reg == SHIFT) & shift_reg[0];
  assign io_out[1]   = (state_reg == SHIFT);
  assign io_out[2]   = (state_reg == SHIFT) & (bit_cnt_reg == 3'd0);
  assign io_out[3]   = fifo_full;
  assign io_out[4]   = fifo_empty;
  assign io_out[5]   = overflow_reg;
  assign io_out[7:6] = state_reg;

endmodule

// File: tb/tb_hm_tx_sched.sv
// Bench for hm_tx_sched: directed scenarios plus random traffic, every cycle's
// io_out compared against a frame-position reference model with a word queue.

module tb_hm_tx_sched;
  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int IDLE_POS = 7 + GAP;
  localparam logic [3:0] MASK [7] = '{4'b1011, 4'b1101, 4'b0001, 4'b1110,
                                      4'b0010, 4'b0100, 4'b1000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] word = 4'h0;
  logic       strobe = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {enable, strobe, word, rst, clk};

  hm_tx_sched #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: queued words, position within the current frame
  // (0..6 = codeword bits, 7..IDLE_POS-1 = gap, IDLE_POS = idle).
  logic [3:0] mq[$];
  int         pos = IDLE_POS;
  logic [6:0] mcw = '0;
  bit         mstrobe_q = 1'b0;
  bit         movf = 1'b0;
  logic [6:0] cap = '0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%02h expected=%02h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] e;
    for (int i = 0; i < 7; i++) e[i] = ^(d & MASK[i]);
    return e;
  endfunction

  function automatic logic [7:0] expected();
    logic [7:0] e;
    e = '0;
    if (pos < 7) begin
      e[0]   = mcw[pos];
      e[1]   = 1'b1;
      e[2]   = (pos == 0);
      e[7:6] = 2'b01;
    end else if (pos < IDLE_POS) begin
      e[7:6] = 2'b10;
    end
    e[3] = (mq.size() == DEPTH);
    e[4] = (mq.size() == 0);
    e[5] = movf;
    return e;
  endfunction

  task automatic model_edge();
    bit pop_m, push_m;
    logic [3:0] h;
    if (rst) begin
      mq.delete();
      pos = IDLE_POS;
      mcw = '0;
      mstrobe_q = 1'b0;
      movf = 1'b0;
    end else begin
      pop_m  = (pos >= IDLE_POS) && enable && (mq.size() > 0);
      push_m = strobe && !mstrobe_q;
      if (pop_m) begin
        h = mq.pop_front();
        mcw = enc(h);
        $display("frame word=%h codeword=%02h t=%0t", h, mcw, $time);
      end
      if (push_m) begin
        if (mq.size() < DEPTH) mq.push_back(word);
        else movf = 1'b1;
      end
      if (pop_m) pos = 0;
      else if (pos < IDLE_POS) pos++;
      mstrobe_q = strobe;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("io_out", io_out, expected());
    if (io_out[1]) cap = {io_out[0], cap[6:1]};
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [3:0] w);
    word = w;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
  endtask

  initial begin
    // Single word 0xB -> codeword 0x55
    do_reset();
    check("reset_state", io_out, 8'h10);
    enable = 1'b1;
    cap = '0;
    push_word(4'hB);
    steps(14);
    check("cw_0xB", {1'b0, cap}, 8'h55);

    // Back-to-back words queued while the first frame shifts
    push_word(4'h1);
    push_word(4'hF);
    push_word(4'h0);
    steps(36);
    check("empty_after_b2b", {7'b0, io_out[4]}, 8'h01);

    // Overflow with enable low, then drain
    do_reset();
    enable = 1'b0;
    push_word(4'h2);
    push_word(4'h4);
    push_word(4'h8);
    push_word(4'hC);
    check("full_after_4", {7'b0, io_out[3]}, 8'h01);
    push_word(4'h7);
    check("ovf_after_5", {7'b0, io_out[5]}, 8'h01);
    enable = 1'b1;
    steps(45);
    check("ovf_sticky", {5'b0, io_out[5:3]}, 8'h06);

    // Strobe held high: single push, then a second after release
    do_reset();
    enable = 1'b0;
    word = 4'h3;
    strobe = 1'b1;
    steps(10);
    strobe = 1'b0;
    step();
    push_word(4'h3);
    check("two_pushes_queued", {5'b0, io_out[5:3]}, 8'h00);

    // Reset during codeword bit 3
    enable = 1'b1;
    begin : wait_bit3
      bit hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
        step();
        if (pos == 3) hit = 1'b1;
      end
      check("wait_bit3", {7'b0, hit}, 8'h01);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("reset_midframe", io_out, 8'h10);
    steps(15);

    // Full FIFO, enable rises on the same edge a push arrives
    do_reset();
    enable = 1'b0;
    push_word(4'h9);
    push_word(4'hA);
    push_word(4'h5);
    push_word(4'h6);
    enable = 1'b1;
    word = 4'hE;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    check("full_push_pop", {5'b0, io_out[5:3]}, 8'h01);
    steps(50);

    // Random traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      strobe = ($urandom_range(0, 2) == 0);
      word   = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    strobe = 1'b0;
    steps(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
